fp_mul_round_normalize: RTL and testbench
=========================================

# fp_mul_round_normalize

Two-stage pipelined normalize-and-round stage of the single-precision floating-point multiplier. It sits directly downstream of the 24x24 mantissa multiplier and takes the raw 48-bit significand product, the result sign and the pre-computed biased exponent. It normalizes the product and rounds it to nearest-even. It then packs the IEEE-754 binary32 result and raises overflow, underflow and inexact flags. A valid/ready handshake is used on both sides.

## Interface
- No parameters. Widths are fixed for binary32.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a product this cycle.
- in_ready  output  1  stage can accept a product this cycle (combinational).
- Mr  input  48  unsigned significand product, {1,f1}*{1,f2}.
- sign_in  input  1  result sign, s1^s2.
- exp_in  input  10  two's-complement biased exponent, E1+E2-127. Legal range -125..381.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result this cycle.
- result  output  32  packed binary32 {sign, exp[7:0], frac[22:0]}.
- overflow  output  1  result saturated to infinity.
- underflow  output  1  result flushed to zero.
- inexact  output  1  rounding discarded nonzero bits, or overflow/underflow occurred.

## Operation
- A transfer occurs when in_valid & in_ready. Output is consumed when out_valid & out_ready.
- Inputs are normal numbers only. Denormal inputs are not supported upstream.
- Mr[47:46]==00 means a zero product. In that case result = {sign_in, 31'b0}, and all flags are 0.
- **Stage 1, normalize. Registers s1_valid, sign, mant[22:0], guard, sticky, exp[9:0], zero:**
  - If Mr[47]=1: mant=Mr[46:24], guard=Mr[23], sticky=|Mr[22:0], exp=exp_in+1.
  - Else: mant=Mr[45:23], guard=Mr[22], sticky=|Mr[21:0], exp=exp_in.
- **Stage 2, round and pack. Registers drive the outputs:**
  - round_up = guard & (sticky | mant[0]).
  - {c, m} = mant + round_up, 24-bit sum.
  - If c=1: m=0 and exp=exp+1.
  - inexact = guard | sticky.
  - If exp >= 255 (signed): result = {sign, 8'hFF, 23'b0}, overflow=1, inexact=1.
  - Else if exp <= 0 (signed): result = {sign, 31'b0}, underflow=1, inexact=1.
  - Else: result = {sign, exp[7:0], m}.
  - Exponent arithmetic is 10-bit signed throughout. It cannot wrap for legal exp_in.
- **Flow control:**
  - s2_advance = !out_valid | out_ready.
  - s1_advance = !s1_valid | s2_advance.
  - in_ready = s1_advance.
  - Each stage loads only when its advance is true. Otherwise it holds.
- When stalled, result and flags stay stable while out_valid=1.
- Order is preserved. No data is dropped or duplicated.

## Timing
- Latency is 2 cycles. Data accepted at edge N appears on the outputs after edge N+1, when out_ready is held high.
- Throughput is 1 result per cycle with no stall.
- Reset values: out_valid=0, s1_valid=0, result=32'h0, overflow=0, underflow=0, inexact=0. in_ready=1 after reset.
- Reset asserted mid-operation discards both stages immediately. out_valid drops asynchronously.
- A full pipeline with out_ready=0 gives in_ready=0 in the same cycle.
- A simultaneous output pop and input push while full proceeds with no bubble.
- The capacity is exactly 2 entries.
- in_ready must not depend on in_valid.

## Test plan
- **1.0*1.0:**
  - Stimulus: Mr=48'h4000_0000_0000, exp_in=127, sign 0, out_ready=1.
  - Response: result=32'h3F80_0000 exactly 2 cycles later. Flags 0.
- **Normalize shift, 1.5*1.5:**
  - Stimulus: Mr=48'h9000_0000_0000, exp_in=127.
  - Response: result=32'h4010_0000, inexact=0.
- **Ties-to-even:**
  - Stimulus A: Mr=48'h4000_0040_0000 (lsb 0, exact tie), exp_in=127.
  - Response A: result=32'h3F80_0000, inexact=1.
  - Stimulus B: Mr=48'h4000_00C0_0000 (lsb 1, tie), exp_in=127.
  - Response B: result=32'h3F80_0002, inexact=1.
- **Rounding carry-out:**
  - Stimulus: Mr=48'h7FFF_FFC0_0000, exp_in=127.
  - Response: result=32'h4000_0000, inexact=1.
- **Overflow and underflow:**
  - Stimulus A: Mr=48'h8000_0000_0000, exp_in=254, sign 1.
  - Response A: result=32'hFF80_0000, overflow=1, inexact=1.
  - Stimulus B: Mr=48'h4000_0000_0000, exp_in=0.
  - Response B: result=32'h0000_0000, underflow=1, inexact=1.
- **Backpressure and reset:**
  - Stimulus: offer 4 back-to-back products with out_ready=0 for 5 cycles, then set out_ready=1.
  - Response: 2 products are accepted and in_ready=0 afterwards. Outputs hold stable. All 4 results emerge in order after release.
  - Stimulus: assert rst mid-stream.
  - Response: out_valid=0 at once, and no stale result is emitted afterwards.

Source files
------------

// File: rtl/fp_mul_round_normalize.sv
// fp_mul_round_normalize
//
// Normalize-and-round back end of the binary32 multiplier. The stage accepts the raw
// 48-bit significand product from the 24x24 mantissa multiplier, the result sign and
// the pre-biased exponent. It produces the packed IEEE-754 result with round-to-
// nearest-even, saturating overflow to infinity and flushing underflow to zero.
//
// Pipeline: stage 1 normalizes (1-bit shift, guard/sticky extraction, exponent fixup);
// stage 2 rounds, detects range errors and registers the packed result and flags.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears both stages
//   in_valid   upstream offers a product this cycle
//   in_ready   stage can take a product this cycle (combinational, independent of in_valid)
//   Mr         48-bit unsigned significand product {1,f1}*{1,f2}
//   sign_in    result sign s1^s2
//   exp_in     10-bit two's-complement biased exponent E1+E2-127
//   out_valid  result/flags are valid
//   out_ready  downstream takes the result this cycle
//   result     packed {sign, exp[7:0], frac[22:0]}
//   overflow   result saturated to infinity
//   underflow  result flushed to zero
//   inexact    rounding dropped nonzero bits, or overflow/underflow occurred
//
// Handshake: a word moves across an interface on a rising edge where valid and ready
// are both high. A producer holding valid keeps its data stable until it is taken;
// ready never looks at valid. Each register stage loads only when it is empty or the
// stage after it is draining in the same cycle, so two entries fit and a full
// pipeline accepts a new product on the same edge it hands one downstream.

module fp_mul_round_normalize (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] Mr,
  input  logic        sign_in,
  input  logic [9:0]  exp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s2_advance;
  logic s1_advance;

  assign s2_advance = !out_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = s1_advance;

  // ---------------------------------------------------------------------------
  // Stage 1: normalize
  // ---------------------------------------------------------------------------
  // The product of two values in [1,2) lies in [1,4): bit 47 set means [2,4) and
  // the binary point moves one place left, bumping the exponent.
  logic        norm_top;
  logic [22:0] norm_mant;
  logic        norm_guard;
  logic        norm_sticky;
  logic [9:0]  norm_exp;
  logic        norm_zero;

  assign norm_top    = Mr[47];
  assign norm_mant   = norm_top ? Mr[46:24] : Mr[45:23];
  assign norm_guard  = norm_top ? Mr[23]    : Mr[22];
  assign norm_sticky = norm_top ? (|Mr[22:0]) : (|Mr[21:0]);
  assign norm_exp    = exp_in + {9'b0, norm_top};
  assign norm_zero   = (Mr[47:46] == 2'b00);

  logic        s1_sign;
  logic [22:0] s1_mant;
  logic        s1_guard;
  logic        s1_sticky;
  logic [9:0]  s1_exp;
  logic        s1_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_mant   <= 23'b0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_exp    <= 10'b0;
      s1_zero   <= 1'b0;
    end else if (s1_advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign   <= sign_in;
        s1_mant   <= norm_mant;
        s1_guard  <= norm_guard;
        s1_sticky <= norm_sticky;
        s1_exp    <= norm_exp;
        s1_zero   <= norm_zero;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: round to nearest even, range check, pack
  // ---------------------------------------------------------------------------
  logic        round_up;
  logic [23:0] round_sum;
  logic [9:0]  round_exp;
  logic        range_ovf;
  logic        range_unf;

  assign round_up  = s1_guard & (s1_sticky | s1_mant[0]);
  assign round_sum = {1'b0, s1_mant} + {23'b0, round_up};
  // A carry out of the fraction means the significand became exactly 2.0; the
  // fraction bits are already all zero, so only the exponent needs the bump.
  assign round_exp = s1_exp + {9'b0, round_sum[23]};
  assign range_ovf = ($signed(round_exp) >= 10'sd255);
  assign range_unf = ($signed(round_exp) <= 10'sd0);

  logic [31:0] pack_result;
  logic        pack_ovf;
  logic        pack_unf;
  logic        pack_inexact;

  always_comb begin
    pack_result  = {s1_sign, 31'b0};
    pack_ovf     = 1'b0;
    pack_unf     = 1'b0;
    pack_inexact = 1'b0;
    if (s1_zero) begin
      // signed zero, exact: the exponent is meaningless for a zero product
      pack_result = {s1_sign, 31'b0};
    end else if (range_ovf) begin
      pack_result  = {s1_sign, 8'hFF, 23'b0};
      pack_ovf     = 1'b1;
      pack_inexact = 1'b1;
    end else if (range_unf) begin
      pack_result  = {s1_sign, 31'b0};
      pack_unf     = 1'b1;
      pack_inexact = 1'b1;
    end else begin
      pack_result  = {s1_sign, round_exp[7:0], round_sum[22:0]};
      pack_inexact = s1_guard | s1_sticky;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= 32'h0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      // Data registers only change when a real entry arrives, so an idle
      // output keeps showing the last result.
      if (s1_valid) begin
        result    <= pack_result;
        overflow  <= pack_ovf;
        underflow <= pack_unf;
        inexact   <= pack_inexact;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_round_normalize.sv
// tb_fp_mul_round_normalize
//
// Self-checking bench for fp_mul_round_normalize. Directed vectors check exact
// results and 2-cycle latency; a backpressure and a mid-stream reset sequence check
// flow control; a randomized run checks every result against a reference model that
// rounds the full-width product with integer arithmetic.
//
// Ports: none (top-level bench).

module tb_fp_mul_round_normalize;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] mr;
  logic        sign_in;
  logic [9:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  always #5 clk = ~clk;

  fp_mul_round_normalize dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Mr        (mr),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  bit          accepted;
  bit          held_v = 1'b0;
  logic [34:0] held_d;
  logic [34:0] exp_q[$];

  // {overflow, underflow, inexact, result[31:0]}
  function automatic logic [34:0] observed();
    return {overflow, underflow, inexact, result};
  endfunction

  // Reference model: round the whole product to a 24-bit significand by integer
  // division by a power of two, ties to even, then range-check the exponent.
  function automatic logic [34:0] model(input logic [47:0] m, input logic s,
                                        input logic [9:0] e);
    longint unsigned p;
    longint unsigned q;
    longint unsigned rem;
    longint unsigned half;
    int              sh;
    int              ex;
    bit              inex;
    p = 64'(m);
    if (m[47:46] == 2'b00) return {3'b000, s, 31'b0};
    sh   = m[47] ? 24 : 23;
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    ex   = int'($signed(e)) + (m[47] ? 1 : 0);
    inex = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {3'b101, s, 8'hFF, 23'b0};
    if (ex <= 0)   return {3'b011, s, 31'b0};
    return {2'b00, inex, s, ex[7:0], q[22:0]};
  endfunction

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Samples both interfaces at the falling edge, ahead of the edge where the
  // transfers actually happen.
  task automatic sample();
    logic [34:0] e;
    accepted = 1'b0;
    if (rst) begin
      held_v = 1'b0;
      return;
    end
    if (held_v && out_valid) chk("stall_hold", observed(), held_d);
    held_v = out_valid && !out_ready;
    held_d = observed();
    if (out_valid && out_ready) begin
      pops++;
      chk("pop_has_expect", {34'b0, exp_q.size() != 0}, 35'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", observed(), e);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(mr, sign_in, exp_in));
      accepted = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    int a;
    int b;
    int t;
    case ($urandom_range(0, 9))
      0: mr = {2'b00, 14'($urandom), 32'($urandom)};
      1: mr = {16'($urandom), 32'($urandom)};
      default: begin
        a  = int'($urandom_range(8388608, 16777215));
        b  = int'($urandom_range(8388608, 16777215));
        mr = 48'(longint'(a) * longint'(b));
      end
    endcase
    sign_in = 1'($urandom);
    if ($urandom_range(0, 3) == 0) t = int'($urandom_range(0, 506));
    else                           t = int'($urandom_range(120, 385));
    exp_in = 10'(t - 125);
  endtask

  task automatic directed(input string tag, input logic [47:0] m, input logic s,
                          input logic [9:0] e, input logic [34:0] want);
    mr = m; sign_in = s; exp_in = e;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk({tag, "_accept"}, 35'(accepted), 35'd1);
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 35'(out_valid), 35'd0);
    tick();
    chk({tag, "_lat2_valid"}, 35'(out_valid), 35'd1);
    chk(tag, observed(), want);
    tick();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 35'(exp_q.size()), 35'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          idx;
    int          n;
    int          acc;
    int          pops0;
    logic [34:0] snap;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mr = 48'h0; sign_in = 1'b0; exp_in = 10'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 35'(out_valid), 35'd0);
    chk("reset_outputs",   observed(),     35'd0);
    chk("reset_in_ready",  35'(in_ready),  35'd1);
    rst = 1'b0;
    tick();
    chk("post_reset_in_ready",  35'(in_ready),  35'd1);
    chk("post_reset_out_valid", 35'(out_valid), 35'd0);

    // exact results and flags: {ovf, unf, inexact, result}
    directed("one_x_one",  48'h4000_0000_0000, 1'b0, 10'd127, {3'b000, 32'h3F80_0000});
    directed("norm_shift", 48'h9000_0000_0000, 1'b0, 10'd127, {3'b000, 32'h4010_0000});
    directed("tie_even",   48'h4000_0040_0000, 1'b0, 10'd127, {3'b001, 32'h3F80_0000});
    directed("tie_odd",    48'h4000_00C0_0000, 1'b0, 10'd127, {3'b001, 32'h3F80_0002});
    directed("carry_out",  48'h7FFF_FFC0_0000, 1'b0, 10'd127, {3'b001, 32'h4000_0000});
    directed("overflow",   48'h8000_0000_0000, 1'b1, 10'd254, {3'b101, 32'hFF80_0000});
    directed("underflow",  48'h4000_0000_0000, 1'b0, 10'd0,   {3'b011, 32'h0000_0000});
    directed("zero_prod",  48'h0000_1234_5678, 1'b1, 10'd300, {3'b000, 32'h8000_0000});
    directed("max_normal", 48'h7FFF_FF80_0000, 1'b0, 10'd254, {3'b000, 32'h7F7F_FFFF});
    directed("min_normal", 48'h4000_0000_0000, 1'b1, 10'd1,   {3'b000, 32'h8080_0000});

    // backpressure: four products offered, downstream stalled for five cycles
    out_ready = 1'b0;
    idx = 0;
    snap = 35'd0;
    rand_inputs();
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (accepted) begin
        idx++;
        rand_inputs();
      end
      if (c == 2) snap = observed();
    end
    chk("bp_accepted_two", 35'(idx),       35'd2);
    chk("bp_in_ready_low", 35'(in_ready),  35'd0);
    chk("bp_out_valid",    35'(out_valid), 35'd1);
    chk("bp_outputs_held", observed(),     snap);
    pops0 = pops;
    out_ready = 1'b1;
    #1;
    chk("bp_full_push_pop_ready", 35'(in_ready), 35'd1);
    n = 0;
    while (idx < 4 && n < 20) begin
      tick();
      n++;
      if (accepted) begin
        idx++;
        if (idx < 4) rand_inputs();
      end
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 35'(idx), 35'd4);
    drain("bp_drain");
    chk("bp_four_results", 35'(pops - pops0), 35'd4);

    // reset in the middle of traffic with both stages occupied
    out_ready = 1'b0;
    rand_inputs();
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (accepted) rand_inputs();
    end
    chk("pre_reset_out_valid", 35'(out_valid), 35'd1);
    rst = 1'b1;
    #1;
    chk("mid_reset_out_valid", 35'(out_valid), 35'd0);
    chk("mid_reset_in_ready",  35'(in_ready),  35'd1);
    chk("mid_reset_outputs",   observed(),     35'd0);
    exp_q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("no_stale_after_reset", 35'(out_valid), 35'd0);
    end

    // randomized traffic with random backpressure
    acc = 0;
    n = 0;
    while (acc < 300 && n < 5000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      rand_inputs();
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      if (accepted) acc++;
      n++;
    end
    chk("rand_accepted", 35'(acc), 35'd300);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
